serial_pad_poller: RTL and testbench



---
 rtl/serial_pad_pkg.sv | 25 ++
 rtl/serial_pad_lane.sv | 86 ++++++++
 rtl/serial_pad_poller.sv | 183 ++++++++++++++++++
 tb/tb_serial_pad_poller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pad_pkg.sv
// Shared types and default timing for the serial gamepad poller.
package serial_pad_pkg;

   // Poller sequencing states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      FIRST  = 3'd2,
      HIGH   = 3'd3,
      LOW    = 3'd4,
      COMMIT = 3'd5,
      GAP    = 3'd6
   } pad_state_e;

   // Frame widths of the supported controller families.
   localparam int NES_BITS  = 8;
   localparam int SNES_BITS = 16;

   // Default timing for a 64 MHz system clock.
   localparam int DEF_LATCH_CYCLES = 768;    // 12 us latch pulse
   localparam int DEF_HALF_CYCLES  = 384;    // 6 us clock half-period
   localparam int DEF_GAP_CYCLES   = 64000;  // 1 ms between frames
   localparam int DEF_CNT_W        = 17;

endpackage

// File: rtl/serial_pad_lane.sv
// Per-pad datapath: raw shift capture, presence check, committed buttons
// and sticky press events for a single controller data line.
module serial_pad_lane
   import serial_pad_pkg::*;
#(
   parameter int NUM_BITS = 16,
   parameter int IDX_W    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pad_data,
   input  logic                sample_en,
   input  logic [IDX_W-1:0]    sample_idx,
   input  logic                commit,
   input  logic                evt_clear,
   output logic [NUM_BITS-1:0] buttons,
   output logic                present,
   output logic [NUM_BITS-1:0] press_evt
);

   logic [NUM_BITS-1:0] raw_q, raw_d;
   logic [NUM_BITS-1:0] buttons_q, buttons_d;
   logic                present_q, present_d;
   logic [NUM_BITS-1:0] press_evt_q, press_evt_d;
   logic                frame_present_s;
   logic [NUM_BITS-1:0] frame_buttons_s;

   // Capture samples, decide presence and build the next committed view.
   always_comb begin
      raw_d       = raw_q;
      buttons_d   = buttons_q;
      present_d   = present_q;
      press_evt_d = press_evt_q;

      if (sample_en) begin
         raw_d[sample_idx] = pad_data;
      end else begin
         raw_d = raw_q;
      end

      // A line that never left low carries no device.
      frame_present_s = |raw_q;
      if (frame_present_s) begin
         frame_buttons_s = ~raw_q;
      end else begin
         frame_buttons_s = {NUM_BITS{1'b0}};
      end

      if (evt_clear) begin
         press_evt_d = {NUM_BITS{1'b0}};
      end else begin
         press_evt_d = press_evt_q;
      end

      // New presses are OR-ed in after the clear so they survive a
      // coincident evt_clear.
      if (commit) begin
         buttons_d   = frame_buttons_s;
         present_d   = frame_present_s;
         press_evt_d = press_evt_d | (frame_buttons_s & ~buttons_q);
      end else begin
         buttons_d   = buttons_q;
         present_d   = present_q;
      end
   end

   // Lane state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         raw_q       <= {NUM_BITS{1'b0}};
         buttons_q   <= {NUM_BITS{1'b0}};
         present_q   <= 1'b0;
         press_evt_q <= {NUM_BITS{1'b0}};
      end else begin
         raw_q       <= raw_d;
         buttons_q   <= buttons_d;
         present_q   <= present_d;
         press_evt_q <= press_evt_d;
      end
   end

   assign buttons   = buttons_q;
   assign present   = present_q;
   assign press_evt = press_evt_q;

endmodule

// File: rtl/serial_pad_poller.sv
// Continuous poller for NUM_PADS latch/clock/data gamepads sharing one
// latch and one shift clock; one sequencer drives all lanes in lockstep.
module serial_pad_poller
   import serial_pad_pkg::*;
#(
   parameter int NUM_PADS     = 2,
   parameter int NUM_BITS     = 16,
   parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
   parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_PADS-1:0]          pad_data,
   output logic                         pad_latch,
   output logic                         pad_clk,
   output logic [NUM_PADS*NUM_BITS-1:0] buttons,
   output logic [NUM_PADS-1:0]          present,
   output logic [NUM_PADS*NUM_BITS-1:0] press_evt,
   input  logic                         evt_clear,
   output logic                         frame_valid,
   output logic                         busy
);

   localparam int IDX_W = $clog2(NUM_BITS);

   // Phase counters run 0..N-1, so each phase ends on N-1.
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

   pad_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             pad_latch_q, pad_latch_d;
   logic             pad_clk_q, pad_clk_d;
   logic             frame_valid_q, frame_valid_d;
   logic             busy_q, busy_d;
   logic             sample_en_s;
   logic [IDX_W-1:0] sample_idx_s;
   logic             commit_s;

   // Next-state, phase timing and sample/commit strobes.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      sample_en_s  = 1'b0;
      sample_idx_s = idx_q;
      commit_s     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = CNT_W'(0);
            idx_d = IDX_W'(0);
            if (enable) begin
               state_d = LATCH;
            end else begin
               state_d = IDLE;
            end
         end
         LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               cnt_d   = CNT_W'(0);
               state_d = FIRST;
            end else begin
               state_d = LATCH;
            end
         end
         FIRST: begin
            // Bit 0 is on the line right after the latch falls.
            if (cnt_q == HALF_LAST) begin
               cnt_d        = CNT_W'(0);
               sample_en_s  = 1'b1;
               sample_idx_s = IDX_W'(0);
               idx_d        = IDX_W'(1);
               state_d      = HIGH;
            end else begin
               state_d = FIRST;
            end
         end
         HIGH: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d       = CNT_W'(0);
               sample_en_s = 1'b1;
               state_d     = LOW;
            end else begin
               state_d = HIGH;
            end
         end
         LOW: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = CNT_W'(0);
               if (idx_q == IDX_LAST) begin
                  state_d = COMMIT;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = HIGH;
               end
            end else begin
               state_d = LOW;
            end
         end
         COMMIT: begin
            cnt_d    = CNT_W'(0);
            idx_d    = IDX_W'(0);
            commit_s = 1'b1;
            state_d  = GAP;
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = CNT_W'(0);
               if (enable) begin
                  state_d = LATCH;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = GAP;
            end
         end
         default: begin
            cnt_d   = CNT_W'(0);
            idx_d   = IDX_W'(0);
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      pad_latch_d   = (state_d == LATCH);
      pad_clk_d     = (state_d == HIGH);
      busy_d        = (state_d != IDLE);
      frame_valid_d = commit_s;
   end

   // Sequencer and registered pin/status outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= CNT_W'(0);
         idx_q         <= IDX_W'(0);
         pad_latch_q   <= 1'b0;
         pad_clk_q     <= 1'b0;
         frame_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         pad_latch_q   <= pad_latch_d;
         pad_clk_q     <= pad_clk_d;
         frame_valid_q <= frame_valid_d;
         busy_q        <= busy_d;
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
      serial_pad_lane #(
         .NUM_BITS (NUM_BITS),
         .IDX_W    (IDX_W)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .pad_data   (pad_data[p]),
         .sample_en  (sample_en_s),
         .sample_idx (sample_idx_s),
         .commit     (commit_s),
         .evt_clear  (evt_clear),
         .buttons    (buttons[p*NUM_BITS +: NUM_BITS]),
         .present    (present[p]),
         .press_evt  (press_evt[p*NUM_BITS +: NUM_BITS])
      );
   end

   assign pad_latch   = pad_latch_q;
   assign pad_clk     = pad_clk_q;
   assign frame_valid = frame_valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_serial_pad_poller.sv
// Bench: behavioural pad devices plus a frame-timeline model of the poller.
module tb_serial_pad_poller;

   localparam int NP = 2;
   localparam int NB = 8;
   localparam int L  = 4;
   localparam int H  = 2;
   localparam int G  = 8;
   localparam int TC = L + H + 2*H*(NB-1);   // frame offset of the commit cycle
   localparam int P  = TC + 1 + G;           // frame period

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (NES width, two pads)
   logic              reset = 1'b1, enable = 1'b0, evt_clear = 1'b0;
   logic [NP-1:0]     pad_data = '0;
   logic              pad_latch, pad_clk, frame_valid, busy;
   logic [NP*NB-1:0]  buttons, press_evt;
   logic [NP-1:0]     present;

   serial_pad_poller #(.NUM_PADS(NP), .NUM_BITS(NB), .LATCH_CYCLES(L),
                       .HALF_CYCLES(H), .GAP_CYCLES(G), .CNT_W(17)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pad_data(pad_data),
      .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
      .present(present), .press_evt(press_evt), .evt_clear(evt_clear),
      .frame_valid(frame_valid), .busy(busy));

   // SNES-width DUT (one pad)
   logic        s_reset = 1'b1, s_enable = 1'b0, s_evt_clear = 1'b0;
   logic [0:0]  s_pad_data = '0;
   logic        s_pad_latch, s_pad_clk, s_frame_valid, s_busy;
   logic [15:0] s_buttons, s_press_evt;
   logic [0:0]  s_present;

   serial_pad_poller #(.NUM_PADS(1), .NUM_BITS(16), .LATCH_CYCLES(L),
                       .HALF_CYCLES(H), .GAP_CYCLES(G), .CNT_W(17)) dut_snes (
      .clk(clk), .reset(s_reset), .enable(s_enable), .pad_data(s_pad_data),
      .pad_latch(s_pad_latch), .pad_clk(s_pad_clk), .buttons(s_buttons),
      .present(s_present), .press_evt(s_press_evt), .evt_clear(s_evt_clear),
      .frame_valid(s_frame_valid), .busy(s_busy));

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   // Pad devices: pressed vectors set by the stimulus, snapshot on latch.
   logic [NB-1:0] pressed [NP];
   logic [NB-1:0] snap    [NP];
   logic          absent  [NP];
   logic          snap_abs[NP];
   int            k       [NP];
   logic          clk_prev = 1'b0;

   // Reference model: position within the frame timeline plus committed view.
   bit            chk_en   = 1'b0;
   bit            m_active = 1'b0;
   int            m_t      = 0;
   logic [NP*NB-1:0] m_btn = '0, m_evt = '0, nb, nevt;
   logic [NP-1:0]    m_pres = '0;
   logic          pres_b;
   logic          exp_latch, exp_clk, exp_fv;

   initial begin
      for (int p = 0; p < NP; p++) begin
         pressed[p] = '0; snap[p] = '0; absent[p] = 1'b0; snap_abs[p] = 1'b0; k[p] = 0;
      end
   end

   // Compare DUT against the model, let pads react, then advance the model.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_latch = m_active && (m_t < L);
         exp_clk   = m_active && (m_t >= L+H) && (m_t < TC) && ((((m_t-L-H)/H) % 2) == 0);
         exp_fv    = m_active && (m_t == TC+1);
         chk("pad_latch",   pad_latch,   exp_latch);
         chk("pad_clk",     pad_clk,     exp_clk);
         chk("busy",        busy,        m_active);
         chk("frame_valid", frame_valid, exp_fv);
         chk("buttons",     buttons,     m_btn);
         chk("present",     present,     m_pres);
         chk("press_evt",   press_evt,   m_evt);
      end

      for (int p = 0; p < NP; p++) begin
         if (pad_latch === 1'b1) begin
            snap[p] = pressed[p]; snap_abs[p] = absent[p]; k[p] = 0;
         end else if (pad_clk === 1'b1 && clk_prev == 1'b0 && k[p] < NB-1) begin
            k[p]++;
         end
         pad_data[p] = snap_abs[p] ? 1'b0 : ~snap[p][k[p]];
      end
      clk_prev = (pad_clk === 1'b1);

      if (reset) begin
         m_active = 1'b0; m_t = 0; m_btn = '0; m_pres = '0; m_evt = '0;
      end else begin
         nevt = evt_clear ? '0 : m_evt;
         if (m_active && m_t == TC) begin
            for (int p = 0; p < NP; p++) begin
               pres_b = !snap_abs[p] && (snap[p] != {NB{1'b1}});
               m_pres[p] = pres_b;
               nb[p*NB +: NB] = pres_b ? snap[p] : '0;
            end
            nevt  = nevt | (nb & ~m_btn);
            m_btn = nb;
         end
         m_evt = nevt;
         if (!m_active) begin
            if (enable) begin m_active = 1'b1; m_t = 0; end
         end else if (m_t == P-1) begin
            if (enable) m_t = 0; else m_active = 1'b0;
         end else begin
            m_t++;
         end
      end
   end

   // SNES pad device.
   logic [15:0] s_pressed = 16'h0A5C;
   logic [15:0] s_snap = '0;
   int          s_k = 0;
   logic        s_clk_prev = 1'b0;

   // SNES pad reacts to its latch and clock.
   always @(negedge clk) begin
      if (s_pad_latch === 1'b1) begin
         s_snap = s_pressed; s_k = 0;
      end else if (s_pad_clk === 1'b1 && s_clk_prev == 1'b0 && s_k < 15) begin
         s_k++;
      end
      s_clk_prev    = (s_pad_clk === 1'b1);
      s_pad_data[0] = ~s_snap[s_k];
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_t(input int target, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 3*P && !hit; i++) begin
         tick();
         if (m_active && m_t == target) hit = 1'b1;
      end
      chk(name, hit, 1'b1);
   endtask

   task automatic wait_fv(input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 3*P && !hit; i++) begin
         tick();
         if (frame_valid === 1'b1) hit = 1'b1;
      end
      chk(name, hit, 1'b1);
   endtask

   int latch_cnt, edge_cnt, fv_seen, fv_first, fv_second;
   logic prev_c;

   initial begin
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_buttons", buttons, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_present", present, 2'b00);

      // Timing: both pads released, two full frames.
      reset = 1'b0; enable = 1'b1;
      latch_cnt = 0; edge_cnt = 0; prev_c = 1'b0; fv_first = -1; fv_second = -1;
      for (int i = 1; i <= 2*P; i++) begin
         tick();
         if (pad_latch) latch_cnt++;
         if (pad_clk && !prev_c) edge_cnt++;
         prev_c = pad_clk;
         if (frame_valid) begin
            if (fv_first < 0) fv_first = i; else fv_second = i;
         end
      end
      chk("latch_cycles", latch_cnt, 8);
      chk("clk_pulses", edge_cnt, 14);
      chk("fv_period", fv_second - fv_first, P);
      chk("idle_buttons", buttons, 16'h0000);
      chk("idle_present", present, 2'b11);

      // Pressed pattern on pad0.
      pressed[0] = 8'hA5; pressed[1] = 8'h00;
      wait_fv("fv_pattern");
      chk("pat_buttons", buttons, 16'h00A5);
      chk("pat_evt", press_evt, 16'h00A5);
      chk("pat_present", present, 2'b11);

      // Absent pad1.
      absent[1] = 1'b1; pressed[1] = 8'h3C;
      wait_fv("fv_absent");
      chk("abs_present", present, 2'b01);
      chk("abs_buttons", buttons, 16'h00A5);
      chk("abs_evt", press_evt, 16'h00A5);

      // Sticky events: bit 3 held over three frames.
      absent[1] = 1'b0; pressed[1] = 8'h00; pressed[0] = 8'h08;
      evt_clear = 1'b1; tick(); evt_clear = 1'b0;
      wait_fv("fv_sticky1");
      chk("sticky1_evt", press_evt, 16'h0008);
      wait_fv("fv_sticky2");
      wait_fv("fv_sticky3");
      chk("sticky3_evt", press_evt, 16'h0008);
      pressed[0] = 8'h18;
      wait_t(TC, "commit_wait");
      evt_clear = 1'b1; tick(); evt_clear = 1'b0;
      chk("clr_commit_fv", frame_valid, 1'b1);
      chk("clr_commit_evt", press_evt, 16'h0010);
      chk("clr_commit_btn", buttons, 16'h0018);

      // Drop enable mid-HIGH: frame completes then idles.
      wait_t(L+H+1, "high_wait");
      enable = 1'b0;
      fv_seen = 0;
      for (int i = 0; i < 2*P && busy; i++) begin
         tick();
         if (frame_valid) fv_seen++;
      end
      chk("drop_fv_count", fv_seen, 1);
      chk("drop_busy", busy, 1'b0);
      repeat (5) tick();
      chk("drop_idle_latch", pad_latch, 1'b0);

      // Reset mid-LOW aborts the frame.
      enable = 1'b1;
      wait_t(L+2*H, "low_wait");
      reset = 1'b1; tick();
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_fv", frame_valid, 1'b0);
      chk("rst_mid_buttons", buttons, 16'h0000);
      chk("rst_mid_evt", press_evt, 16'h0000);
      chk("rst_mid_pins", {pad_latch, pad_clk, present}, 4'b0000);
      reset = 1'b0; tick();
      chk("rst_after_fv", frame_valid, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 24) == 0)
               pressed[p] = ($urandom_range(0, 3) == 0) ? {NB{1'b1}} : NB'($urandom);
            if ($urandom_range(0, 299) == 0) absent[p] = ~absent[p];
         end
         evt_clear = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 399) == 0) enable = ~enable;
         reset = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 1'b0; evt_clear = 1'b0; enable = 1'b0;
      tick();

      // SNES width: 15 clock pulses, bits 12-15 released.
      s_reset = 1'b0; s_enable = 1'b1; tick(); s_enable = 1'b0;
      edge_cnt = 0; prev_c = 1'b0; fv_seen = 0;
      for (int i = 0; i < 200 && fv_seen == 0; i++) begin
         tick();
         if (s_pad_clk && !prev_c) edge_cnt++;
         prev_c = s_pad_clk;
         if (s_frame_valid) fv_seen = 1;
      end
      chk("snes_fv", fv_seen, 1);
      chk("snes_clk_pulses", edge_cnt, 15);
      chk("snes_buttons", s_buttons, 16'h0A5C);
      chk("snes_hi_nibble", s_buttons[15:12], 4'h0);
      chk("snes_present", s_present, 1'b1);
      chk("snes_evt", s_press_evt, 16'h0A5C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
